// File: rtl/step_shaper.sv
// Shapes single-cycle step requests into STEP/DIR pulses with minimum high, gap and dir-setup times.
// Define STEP_SHAPER_DIR_INVERT_EN to drive dir_out inverted (reset value 1).
module step_shaper #(
    parameter int PULSE_CYCLES     = 50,
    parameter int GAP_CYCLES       = 50,
    parameter int DIR_SETUP_CYCLES = 25,
    parameter int PEND_W           = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic step_in,
    input  logic dir_in,
    output logic step_out,
    output logic dir_out,
    output logic busy,
    output logic overflow
);

    localparam int MAX_CYC =
        (PULSE_CYCLES > GAP_CYCLES)
            ? ((PULSE_CYCLES > DIR_SETUP_CYCLES) ? PULSE_CYCLES : DIR_SETUP_CYCLES)
            : ((GAP_CYCLES > DIR_SETUP_CYCLES) ? GAP_CYCLES : DIR_SETUP_CYCLES);
    localparam int TIMER_W = $clog2(MAX_CYC) + 1;

    // Pending arithmetic runs one bit wider so +/-2 excursions never wrap before the limit test.
    localparam logic signed [PEND_W:0] PEND_MAX = (PEND_W+1)'((1 << (PEND_W-1)) - 1);
    localparam logic signed [PEND_W:0] PEND_MIN = -PEND_MAX;

`ifdef STEP_SHAPER_DIR_INVERT_EN
    localparam logic DIR_POL = 1'b1;
`else
    localparam logic DIR_POL = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, SETUP, HIGH, LOW} state_t;

    state_t                    state, state_nxt;
    logic [TIMER_W-1:0]        timer, timer_nxt;
    logic                      dir_int, dir_nxt;
    logic signed [PEND_W-1:0]  pending, pending_nxt;
    logic signed [PEND_W:0]    pend_ext, delta, cons, with_step, no_step;
    logic                      pend_nz, pend_pos, enter_high, drop;

    assign pend_nz  = (pending != '0);
    assign pend_pos = pend_nz && !pending[PEND_W-1];

    always_comb begin
        state_nxt  = state;
        timer_nxt  = timer;
        dir_nxt    = dir_int;
        enter_high = 1'b0;
        case (state)
            IDLE: begin
                if (pend_nz) begin
                    if (pend_pos == dir_int) begin
                        enter_high = 1'b1;
                    end else begin
                        dir_nxt   = pend_pos;
                        timer_nxt = TIMER_W'(DIR_SETUP_CYCLES);
                        state_nxt = SETUP;
                    end
                end
            end
            SETUP: begin
                // A cancelled or reversed backlog finishes setup but re-decides from IDLE.
                if (timer == TIMER_W'(1)) begin
                    if (pend_nz && (pend_pos == dir_int)) begin
                        enter_high = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    timer_nxt = timer - TIMER_W'(1);
                end
            end
            HIGH: begin
                if (timer == TIMER_W'(1)) begin
                    timer_nxt = TIMER_W'(GAP_CYCLES);
                    state_nxt = LOW;
                end else begin
                    timer_nxt = timer - TIMER_W'(1);
                end
            end
            LOW: begin
                if (timer == TIMER_W'(1)) begin
                    state_nxt = IDLE;
                end else begin
                    timer_nxt = timer - TIMER_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (enter_high) begin
            state_nxt = HIGH;
            timer_nxt = TIMER_W'(PULSE_CYCLES);
        end
    end

    // Net the new request against the step consumed this cycle before applying the saturation limit.
    always_comb begin
        pend_ext = {pending[PEND_W-1], pending};
        delta    = '0;
        cons     = '0;
        if (step_in) begin
            delta = dir_in ? (PEND_W+1)'(1) : '1;
        end
        if (enter_high) begin
            cons = pend_pos ? (PEND_W+1)'(1) : '1;
        end
        with_step   = pend_ext + delta - cons;
        no_step     = pend_ext - cons;
        drop        = step_in && ((with_step > PEND_MAX) || (with_step < PEND_MIN));
        pending_nxt = drop ? no_step[PEND_W-1:0] : with_step[PEND_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            timer    <= '0;
            dir_int  <= 1'b0;
            pending  <= '0;
            step_out <= 1'b0;
            dir_out  <= DIR_POL;
            busy     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            state    <= state_nxt;
            timer    <= timer_nxt;
            dir_int  <= dir_nxt;
            pending  <= pending_nxt;
            step_out <= (state == HIGH);
            dir_out  <= dir_int ^ DIR_POL;
            busy     <= (state != IDLE) || pend_nz;
            overflow <= drop;
        end
    end

endmodule

// File: tb/tb_step_shaper.sv
// Directed and randomized bench for step_shaper against an event-time reference model.
// Honours STEP_SHAPER_DIR_INVERT_EN when computing the expected dir_out polarity.
module tb_step_shaper;

    localparam int P    = 4;
    localparam int G    = 5;
    localparam int D    = 3;
    localparam int W    = 4;
    localparam int PMAX = (1 << (W-1)) - 1;
`ifdef STEP_SHAPER_DIR_INVERT_EN
    localparam bit INV = 1'b1;
`else
    localparam bit INV = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic step_in = 1'b0;
    logic dir_in = 1'b0;
    logic step_out, dir_out, busy, overflow;

    step_shaper #(
        .PULSE_CYCLES(P), .GAP_CYCLES(G), .DIR_SETUP_CYCLES(D), .PEND_W(W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .step_in(step_in), .dir_in(dir_in),
        .step_out(step_out), .dir_out(dir_out), .busy(busy), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int check_count = 0;
    int pass_count  = 0;

    // Model: backlog count plus the edge times of the next decision, setup end and last pulse start.
    int m_pend, m_de, m_setup_end, m_rise, n_edge;
    bit m_dir;
    bit nxt_step, nxt_dir, nxt_busy, ov_now;
    bit cur_step, cur_dir, cur_busy;

    int rise_cnt, ov_cnt, first_rise, last_rise;
    bit prev_step;

    task automatic checkOutput(input string tag, input logic obs, input logic expv);
        check_count++;
        assert (obs === expv) pass_count++;
        else $error("[TB] FAIL %s: observed %b expected %b at edge %0d", tag, obs, expv, n_edge);
    endtask

    task automatic checkCount(input string tag, input int obs, input int expv);
        check_count++;
        assert (obs === expv) pass_count++;
        else $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, expv);
    endtask

    task automatic model_reset();
        m_pend      = 0;
        m_dir       = 1'b0;
        m_de        = 0;
        m_setup_end = -1;
        m_rise      = -1000;
        cur_step    = 1'b0;
        cur_dir     = INV;
        cur_busy    = 1'b0;
    endtask

    task automatic model_edge(input bit s, input bit d);
        int c, delta, nv;
        bit pos;
        c   = 0;
        pos = (m_pend > 0);
        if (m_setup_end == n_edge) begin
            m_setup_end = -1;
            if (m_pend != 0 && pos == m_dir) begin
                c      = pos ? 1 : -1;
                m_rise = n_edge;
                m_de   = n_edge + P + G + 1;
            end else begin
                m_de = n_edge + 1;
            end
        end else if (m_setup_end < 0 && n_edge >= m_de && m_pend != 0) begin
            if (pos == m_dir) begin
                c      = pos ? 1 : -1;
                m_rise = n_edge;
                m_de   = n_edge + P + G + 1;
            end else begin
                m_dir       = pos;
                m_setup_end = n_edge + D;
                m_de        = 32'h3fff_ffff;
            end
        end
        delta  = s ? (d ? 1 : -1) : 0;
        nv     = m_pend + delta - c;
        ov_now = 1'b0;
        if (nv > PMAX || nv < -PMAX) begin
            ov_now = 1'b1;
            nv     = m_pend - c;
        end
        m_pend   = nv;
        nxt_step = (n_edge >= m_rise) && (n_edge <= m_rise + P - 1);
        nxt_dir  = m_dir ^ INV;
        nxt_busy = (n_edge < m_de - 1) || (m_pend != 0);
    endtask

    task automatic applyStimulus(input bit s, input bit d);
        @(negedge clk);
        step_in = s;
        dir_in  = d;
        model_edge(s, d);
        @(posedge clk);
        #1;
        checkOutput("step_out", step_out, cur_step);
        checkOutput("dir_out", dir_out, cur_dir);
        checkOutput("busy", busy, cur_busy);
        checkOutput("overflow", overflow, ov_now);
        if (step_out && !prev_step) begin
            rise_cnt++;
            if (first_rise < 0) first_rise = n_edge;
            last_rise = n_edge;
        end
        if (overflow) ov_cnt++;
        prev_step = step_out;
        cur_step  = nxt_step;
        cur_dir   = nxt_dir;
        cur_busy  = nxt_busy;
        n_edge++;
        step_in   = 1'b0;
    endtask

    task automatic idle(input int k);
        repeat (k) applyStimulus(1'b0, 1'b0);
    endtask

    task automatic clear_stats();
        rise_cnt   = 0;
        ov_cnt     = 0;
        first_rise = -1;
        last_rise  = -1;
    endtask

    task automatic doReset();
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_step_out", step_out, 1'b0);
        checkOutput("rst_dir_out", dir_out, INV);
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_overflow", overflow, 1'b0);
        model_reset();
        prev_step = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int e0;
        n_edge    = 0;
        prev_step = 1'b0;
        model_reset();
        doReset();

        // Single reverse step from reset: no setup since internal dir starts at 0.
        clear_stats();
        e0 = n_edge;
        applyStimulus(1'b1, 1'b0);
        idle(20);
        checkCount("c1_pulses", rise_cnt, 1);
        checkCount("c1_rise_edge", first_rise, e0 + 2);
        checkOutput("c1_dir_final", dir_out, INV);

        // Single forward step from reset needs a direction setup first.
        doReset();
        clear_stats();
        e0 = n_edge;
        applyStimulus(1'b1, 1'b1);
        idle(20);
        checkCount("c2_pulses", rise_cnt, 1);
        checkCount("c2_rise_edge", first_rise, e0 + 2 + D);
        checkOutput("c2_dir_final", dir_out, 1'b1 ^ INV);

        // Five back-to-back forward steps.
        clear_stats();
        repeat (5) applyStimulus(1'b1, 1'b1);
        idle(60);
        checkCount("c3_pulses", rise_cnt, 5);
        checkCount("c3_overflow", ov_cnt, 0);
        checkCount("c3_span", last_rise - first_rise, 4 * (P + G + 1));

        // Opposite requests during a pulse cancel out.
        clear_stats();
        applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b1, 1'b0);
        idle(25);
        checkCount("c4_pulses", rise_cnt, 1);
        checkOutput("c4_busy_final", busy, 1'b0);

        // Twelve forward steps saturate the backlog at +7.
        clear_stats();
        repeat (12) applyStimulus(1'b1, 1'b1);
        idle(120);
        checkCount("c5_pulses", rise_cnt, 9);
        checkCount("c5_overflow", ov_cnt, 3);
        checkCount("c5_accounting", rise_cnt, 12 - ov_cnt);

        // Reset in the middle of a pulse with backlog 3 kills the pulse and the backlog.
        doReset();
        repeat (4) applyStimulus(1'b1, 1'b1);
        idle(2);
        checkOutput("c6_high_before_reset", step_out, 1'b1);
        doReset();
        clear_stats();
        idle(30);
        checkCount("c6_pulses_after", rise_cnt, 0);
        checkOutput("c6_busy_after", busy, 1'b0);

        // Random sparse traffic, then a dense burst to exercise saturation in both directions.
        repeat (300) applyStimulus($urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)));
        repeat (60) applyStimulus(1'b1, $urandom_range(0, 9) < 7);
        repeat (40) applyStimulus(1'b1, $urandom_range(0, 9) < 2);
        idle(200);
        checkOutput("final_busy", busy, 1'b0);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
